wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 73 +++++++
 tb/tb_wb_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback register stage with load extraction, x0 suppression and bypass.
// Define WB_INSTRET_EN to build the 64-bit retired-instruction counter.
module wb_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_valid,
   input  logic               i_kill,
   input  logic [RADDR_W-1:0] i_rd_addr,
   input  logic               i_rd_we,
   input  logic               i_is_load,
   input  logic [2:0]         i_funct3,
   input  logic [1:0]         i_byte_off,
   input  logic [XLEN-1:0]    i_alu_result,
   input  logic [XLEN-1:0]    i_load_word,
   output logic [RADDR_W-1:0] o_wr_addr,
   output logic [XLEN-1:0]    o_wr_data,
   output logic               o_wr_en,
   output logic               o_fwd_valid,
   output logic [RADDR_W-1:0] o_fwd_addr,
   output logic [XLEN-1:0]    o_fwd_data,
   output logic               o_load_err,
   output logic               o_retire,
   output logic [63:0]        o_instret
);
   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic            ld_ill, ld_mis, err, v;
   logic [XLEN-1:0] ld_val, nxt_data;
   always_comb begin
      ld_b     = i_load_word[{i_byte_off, 3'b000} +: 8];
      ld_h     = i_byte_off[1] ? i_load_word[31:16] : i_load_word[15:0];
      // funct3 011, 110 and 111 are not loads
      ld_ill   = (i_funct3[1:0] == 2'b11) || (i_funct3[2:1] == 2'b11);
      ld_mis   = (i_funct3[1:0] == 2'b01 && i_byte_off[0]) || (i_funct3 == 3'b010 && i_byte_off != 2'b00);
      err      = i_is_load && (ld_ill || ld_mis);
      ld_val   = i_funct3[1] ? i_load_word :
                 i_funct3[0] ? {{(XLEN-16){~i_funct3[2] & ld_h[15]}}, ld_h} :
                               {{(XLEN-8){~i_funct3[2] & ld_b[7]}}, ld_b};
      nxt_data = i_is_load ? ld_val : i_alu_result;
      v        = i_valid & ~i_kill;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_retire   <= 1'b0;
         o_wr_en    <= 1'b0;
         o_load_err <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
      end else begin
         o_retire   <= v;
         o_wr_en    <= v & i_rd_we & (|i_rd_addr) & ~err;
         o_load_err <= v & err;
         o_wr_addr  <= i_rd_addr;
         o_wr_data  <= nxt_data;
      end
   end
   assign o_fwd_valid = o_wr_en;
   assign o_fwd_addr  = o_wr_addr;
   assign o_fwd_data  = o_wr_data;
`ifdef WB_INSTRET_EN
   logic [63:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt + 64'(o_retire);
   end
   assign o_instret = cnt;
`else
   assign o_instret = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage writes, load extraction, errors, kill, reset and instret.
module tb_wb_stage;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        i_valid = 1'b0, i_kill = 1'b0, i_rd_we = 1'b0, i_is_load = 1'b0;
   logic [4:0]  i_rd_addr = '0;
   logic [2:0]  i_funct3 = '0;
   logic [1:0]  i_byte_off = '0;
   logic [31:0] i_alu_result = '0, i_load_word = '0;
   logic [4:0]  o_wr_addr, o_fwd_addr;
   logic [31:0] o_wr_data, o_fwd_data;
   logic        o_wr_en, o_fwd_valid, o_load_err, o_retire;
   logic [63:0] o_instret;
   logic [31:0] rf [32];
   int          checks = 0, failures = 0, n_ret = 0;
   localparam logic [31:0] W = 32'h8081F2F3;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_kill(i_kill), .i_rd_addr(i_rd_addr),
      .i_rd_we(i_rd_we), .i_is_load(i_is_load), .i_funct3(i_funct3), .i_byte_off(i_byte_off),
      .i_alu_result(i_alu_result), .i_load_word(i_load_word), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_wr_en(o_wr_en), .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr),
      .o_fwd_data(o_fwd_data), .o_load_err(o_load_err), .o_retire(o_retire), .o_instret(o_instret)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (o_wr_en) rf[o_wr_addr] <= o_wr_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic v, input logic k, input logic [4:0] rd, input logic we,
                        input logic ld, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] alu, input logic [31:0] word);
      i_valid = v; i_kill = k; i_rd_addr = rd; i_rd_we = we; i_is_load = ld;
      i_funct3 = f3; i_byte_off = off; i_alu_result = alu; i_load_word = word;
      if (v && !k) n_ret++;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      i_valid = 1'b0; i_kill = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic exp_out(input string tag, input logic en, input logic [4:0] a,
                          input logic [31:0] d, input logic er, input logic rt);
      chk({tag, ".en"}, 64'(o_wr_en), 64'(en));
      chk({tag, ".fwd_en"}, 64'(o_fwd_valid), 64'(en));
      chk({tag, ".err"}, 64'(o_load_err), 64'(er));
      chk({tag, ".ret"}, 64'(o_retire), 64'(rt));
      if (en) begin
         chk({tag, ".addr"}, 64'(o_wr_addr), 64'(a));
         chk({tag, ".data"}, 64'(o_wr_data), 64'(d));
         chk({tag, ".fwd_addr"}, 64'(o_fwd_addr), 64'(a));
         chk({tag, ".fwd_data"}, 64'(o_fwd_data), 64'(d));
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      #12;
      exp_out("rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      chk("rst.data", 64'(o_wr_data), 64'd0);
      chk("rst.instret", o_instret, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      n_ret = 0;
      issue(1, 0, 5'd5, 1, 0, 3'd0, 2'd0, 32'hDEADBEEF, 32'd0);
      exp_out("alu", 1, 5'd5, 32'hDEADBEEF, 0, 1);
      issue(1, 0, 5'd1, 1, 1, 3'b000, 2'd1, 32'd0, W);
      exp_out("lb1", 1, 5'd1, 32'hFFFFFFF2, 0, 1);
      issue(1, 0, 5'd2, 1, 1, 3'b000, 2'd3, 32'd0, W);
      exp_out("lb3", 1, 5'd2, 32'hFFFFFF80, 0, 1);
      issue(1, 0, 5'd3, 1, 1, 3'b100, 2'd3, 32'd0, W);
      exp_out("lbu3", 1, 5'd3, 32'h00000080, 0, 1);
      issue(1, 0, 5'd4, 1, 1, 3'b001, 2'd2, 32'd0, W);
      exp_out("lh2", 1, 5'd4, 32'hFFFF8081, 0, 1);
      issue(1, 0, 5'd6, 1, 1, 3'b101, 2'd0, 32'd0, W);
      exp_out("lhu0", 1, 5'd6, 32'h0000F2F3, 0, 1);
      issue(1, 0, 5'd8, 1, 1, 3'b010, 2'd0, 32'd0, W);
      exp_out("lw0", 1, 5'd8, 32'h8081F2F3, 0, 1);
      issue(1, 0, 5'd9, 1, 0, 3'b011, 2'd3, 32'h12345678, W);
      exp_out("nonld", 1, 5'd9, 32'h12345678, 0, 1);
      issue(1, 0, 5'd7, 1, 1, 3'b010, 2'd2, 32'd0, W);
      exp_out("lw_mis", 0, 5'd7, 32'd0, 1, 1);
      idle();
      exp_out("lw_mis_after", 0, 5'd0, 32'd0, 0, 0);
      issue(1, 0, 5'd7, 1, 1, 3'b011, 2'd0, 32'd0, W);
      exp_out("ill011", 0, 5'd7, 32'd0, 1, 1);
      issue(1, 0, 5'd7, 1, 1, 3'b110, 2'd0, 32'd0, W);
      exp_out("ill110", 0, 5'd7, 32'd0, 1, 1);
      issue(1, 0, 5'd7, 1, 1, 3'b101, 2'd1, 32'd0, W);
      exp_out("lhu_mis", 0, 5'd7, 32'd0, 1, 1);
      issue(1, 0, 5'd0, 1, 0, 3'd0, 2'd0, 32'hAAAA5555, 32'd0);
      exp_out("x0", 0, 5'd0, 32'd0, 0, 1);
      issue(1, 1, 5'd10, 1, 0, 3'd0, 2'd0, 32'h55, 32'd0);
      exp_out("kill", 0, 5'd10, 32'd0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         issue(1, 0, 5'd3, 1, 0, 3'd0, 2'd0, 32'(i), 32'd0);
         exp_out($sformatf("b2b%0d", i), 1, 5'd3, 32'(i), 0, 1);
      end
      idle();
      chk("rf3", 64'(rf[3]), 64'd3);
      chk("rf7", 64'(rf[7]), 64'd0);
      chk("rf10", 64'(rf[10]), 64'd0);
      chk("rf0", 64'(rf[0]), 64'd0);
      rf[11] = '0;
      i_valid = 1'b1; i_kill = 1'b0; i_rd_addr = 5'd11; i_rd_we = 1'b1; i_is_load = 1'b0;
      i_alu_result = 32'hCAFEF00D;
      @(posedge clk); #1;
      exp_out("pre_rst", 1, 5'd11, 32'hCAFEF00D, 0, 1);
      #2 rst_n = 1'b0;
      #1;
      exp_out("async_rst", 0, 5'd0, 32'd0, 0, 0);
      chk("async_rst.data", 64'(o_wr_data), 64'd0);
      chk("async_rst.addr", 64'(o_wr_addr), 64'd0);
      repeat (2) @(posedge clk);
      #1 i_valid = 1'b0;
      rst_n = 1'b1;
      n_ret = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_nowrite", 64'(rf[11]), 64'd0);
      chk("rst_idle.en", 64'(o_wr_en), 64'd0);
      for (int i = 0; i < 20; i++) issue(1, i[0], 5'd12, 1, 0, 3'd0, 2'd0, 32'(i), 32'd0);
      idle();
      idle();
      chk("n_ret", 64'(n_ret), 64'd10);
`ifdef WB_INSTRET_EN
      chk("instret", o_instret, 64'd10);
`else
      chk("instret", o_instret, 64'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
